// File: rtl/draw_card.sv
// Card sprite renderer: walks a 16x16 raster and emits one registered plot pixel per clock.
// Face-up cards show a value bar on a light field, face-down cards show the back colour.
module draw_card #(
  parameter logic [2:0] BORDER_COLOUR  = 3'b111,
  parameter logic [2:0] BACK_COLOUR    = 3'b001,
  parameter logic [2:0] FACE_BG_COLOUR = 3'b111,
  parameter logic [2:0] FACE_COLOUR    = 3'b100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [3:0] card_value,
  input  logic       face_up,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  typedef struct packed {
    logic [7:0] x0;
    logic [6:0] y0;
    logic [3:0] value;
    logic       face_up;
  } card_t;

  state_t     state, state_nx;
  card_t      card;
  logic [7:0] cnt;
  logic [3:0] c, r;
  logic [3:0] bar_v;
  logic [4:0] bar_end;
  logic [2:0] pix_colour;

  assign c = cnt[3:0];
  assign r = cnt[7:4];

  // Values above 12 saturate to a full-width bar (columns 2..13).
  assign bar_v   = (card.value > 4'd12) ? 4'd12 : card.value;
  assign bar_end = 5'd1 + {1'b0, bar_v};

  always_comb begin
    pix_colour = FACE_BG_COLOUR;
    if (c == 4'd0 || c == 4'd15 || r == 4'd0 || r == 4'd15)
      pix_colour = BORDER_COLOUR;
    else if (!card.face_up)
      pix_colour = BACK_COLOUR;
    else if (r >= 4'd2 && r <= 4'd13 && c >= 4'd2 && {1'b0, c} <= bar_end)
      pix_colour = FACE_COLOUR;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = DRAW;
      DRAW:    if (cnt == 8'd255) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      card   <= '0;
      cnt    <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nx;
      plot  <= (state == DRAW);
      done  <= (state == DONE);
      // busy stays high through the done cycle; a start seen in IDLE re-raises it.
      busy  <= (state == IDLE) ? start : 1'b1;
      case (state)
        IDLE: if (start) begin
          card <= '{x0: x0, y0: y0, value: card_value, face_up: face_up};
          cnt  <= '0;
        end
        DRAW: begin
          x      <= card.x0 + {4'b0, c};
          y      <= card.y0 + {3'b0, r};
          colour <= pix_colour;
          cnt    <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_card.sv
// Directed bench for draw_card: vector table of sampled pixels plus handshake corner sequences.
module tb_draw_card;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x0 = '0;
  logic [6:0] y0 = '0;
  logic [3:0] card_value = '0;
  logic       face_up = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  draw_card dut (
    .clk(clk), .reset(reset), .start(start), .x0(x0), .y0(y0),
    .card_value(card_value), .face_up(face_up), .x(x), .y(y),
    .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x0;
    logic [6:0] y0;
    logic [3:0] v;
    logic       fu;
    int         idx;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
  } vec_t;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    int         cyc;
  } pix_t;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  pix_t pix_q[$];
  int   done_q[$];
  vec_t vecs[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (plot) pix_q.push_back('{x, y, colour, cyc});
    if (done) done_q.push_back(cyc);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Starts a draw, scrambles the inputs after acceptance, waits for done plus a few cycles.
  task automatic run_draw(input logic [7:0] ax, input logic [6:0] ay,
                          input logic [3:0] av, input logic afu, output int n);
    pix_q.delete();
    done_q.delete();
    @(negedge clk);
    x0 = ax; y0 = ay; card_value = av; face_up = afu; start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    chk("busy_at_accept", int'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    x0 = ~ax; y0 = ~ay; card_value = ~av; face_up = ~afu;
    for (int k = 0; k < 400 && done_q.size() == 0; k++) @(posedge clk);
    if (done_q.size() == 0) chk("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #2;
    chk("plot_count", pix_q.size(), 256);
    chk("done_count", done_q.size(), 1);
    if (pix_q.size() == 256 && done_q.size() == 1) begin
      chk("first_pix_cyc", pix_q[0].cyc - n, 1);
      chk("last_pix_cyc", pix_q[255].cyc - n, 256);
      chk("done_cyc", done_q[0] - n, 257);
    end
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    int n, cnt_a, cnt_b;

    // x0, y0, value, face_up, pixel index, expected x, y, colour
    vecs.push_back('{8'd10,  7'd20,  4'd3,  1'b1, 0,   8'd10,  7'd20,  3'b111});
    vecs.push_back('{8'd10,  7'd20,  4'd3,  1'b1, 255, 8'd25,  7'd35,  3'b111});
    vecs.push_back('{8'd10,  7'd20,  4'd3,  1'b1, 34,  8'd12,  7'd22,  3'b100});
    vecs.push_back('{8'd10,  7'd20,  4'd3,  1'b1, 36,  8'd14,  7'd22,  3'b100});
    vecs.push_back('{8'd10,  7'd20,  4'd3,  1'b1, 37,  8'd15,  7'd22,  3'b111});
    vecs.push_back('{8'd10,  7'd20,  4'd3,  1'b1, 119, 8'd17,  7'd27,  3'b111});
    vecs.push_back('{8'd0,   7'd0,   4'd5,  1'b0, 17,  8'd1,   7'd1,   3'b001});
    vecs.push_back('{8'd0,   7'd0,   4'd5,  1'b0, 240, 8'd0,   7'd15,  3'b111});
    vecs.push_back('{8'd0,   7'd0,   4'd15, 1'b1, 45,  8'd13,  7'd2,   3'b100});
    vecs.push_back('{8'd0,   7'd0,   4'd15, 1'b1, 46,  8'd14,  7'd2,   3'b111});
    vecs.push_back('{8'd0,   7'd0,   4'd15, 1'b1, 210, 8'd2,   7'd13,  3'b100});
    vecs.push_back('{8'd0,   7'd0,   4'd15, 1'b1, 226, 8'd2,   7'd14,  3'b111});
    vecs.push_back('{8'd0,   7'd0,   4'd12, 1'b1, 45,  8'd13,  7'd2,   3'b100});
    vecs.push_back('{8'd0,   7'd0,   4'd0,  1'b1, 34,  8'd2,   7'd2,   3'b111});
    vecs.push_back('{8'd250, 7'd120, 4'd7,  1'b1, 250, 8'd4,   7'd7,   3'b111});
    vecs.push_back('{8'd250, 7'd120, 4'd7,  1'b1, 0,   8'd250, 7'd120, 3'b111});

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle%0d", i), {x, y, colour, plot, busy, done}, 0);
    end

    foreach (vecs[i]) begin
      run_draw(vecs[i].x0, vecs[i].y0, vecs[i].v, vecs[i].fu, n);
      if (pix_q.size() == 256) begin
        chk($sformatf("v%0d_x", i),   pix_q[vecs[i].idx].x,   vecs[i].ex);
        chk($sformatf("v%0d_y", i),   pix_q[vecs[i].idx].y,   vecs[i].ey);
        chk($sformatf("v%0d_col", i), pix_q[vecs[i].idx].col, vecs[i].ec);
      end
    end

    // Face-down sweep: 196 interior back pixels, 60 border pixels.
    run_draw(8'd0, 7'd0, 4'd9, 1'b0, n);
    cnt_a = 0; cnt_b = 0;
    foreach (pix_q[k]) begin
      if ((k % 16) inside {0, 15} || (k / 16) inside {0, 15}) cnt_b += int'(pix_q[k].col == 3'b111);
      else cnt_a += int'(pix_q[k].col == 3'b001);
    end
    chk("back_interior", cnt_a, 196);
    chk("back_border", cnt_b, 60);

    run_draw(8'd0, 7'd0, 4'd15, 1'b1, n);
    cnt_a = 0;
    foreach (pix_q[k]) cnt_a += int'(pix_q[k].col == 3'b100);
    chk("bar15_pixels", cnt_a, 144);

    run_draw(8'd0, 7'd0, 4'd0, 1'b1, n);
    cnt_a = 0;
    foreach (pix_q[k]) cnt_a += int'(pix_q[k].col == 3'b100);
    chk("bar0_pixels", cnt_a, 0);

    // start pulses at +5 and +257 are ignored; +258 is accepted.
    pix_q.delete();
    done_q.delete();
    @(negedge clk);
    x0 = 8'd30; y0 = 7'd40; card_value = 4'd2; face_up = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    while (cyc < n + 600) begin
      @(negedge clk);
      start = (cyc + 1 == n + 5) || (cyc + 1 == n + 257) || (cyc + 1 == n + 258);
    end
    start = 1'b0;
    #2;
    chk("restart_done_count", done_q.size(), 2);
    chk("restart_pix_count", pix_q.size(), 512);
    if (done_q.size() == 2) begin
      chk("restart_done0", done_q[0] - n, 257);
      chk("restart_done1", done_q[1] - n, 258 + 257);
    end
    if (pix_q.size() == 512) begin
      chk("restart_second_first", pix_q[256].cyc - n, 259);
      chk("restart_second_x", pix_q[256].x, 30);
    end

    // Reset in the middle of a draw.
    pix_q.delete();
    done_q.delete();
    @(negedge clk);
    x0 = 8'd5; y0 = 7'd6; card_value = 4'd4; face_up = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 300 && pix_q.size() < 100; k++) @(posedge clk);
    chk("mid_reached", int'(pix_q.size() >= 100), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(posedge clk);
    #2;
    chk("rst_no_done", done_q.size(), 0);
    chk("rst_idle_plot", int'(plot), 0);
    run_draw(8'd5, 7'd6, 4'd4, 1'b1, n);
    if (pix_q.size() == 256) begin
      chk("post_rst_x0", pix_q[0].x, 5);
      chk("post_rst_y0", pix_q[0].y, 6);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
